alu_exec_16bit: RTL and testbench
=================================

Name: alu_exec_16bit

Overview:
- Execute stage directly downstream of the 16-bit, 32-entry register file.
- Consumes the two read-port values as operands and computes one result per accepted operation.
- Writes the result back through the register file's write port (mode/address/value), so it acts as both consumer and write-back driver.
- Single-cycle logic/add ops; iterative 16-cycle shift-add multiply.

Parameters:
- WIDTH, 16, operand/result width.
- ADDR_W, 5, register address width (32 entries).
- MUL_CYCLES, 16, multiply iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  stage can accept; high only in IDLE.
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 MUL, 111 SRL.
- op1  in  WIDTH  operand A (register file ReadValue1).
- op2  in  WIDTH  operand B (register file ReadValue2).
- dest_addr  in  ADDR_W  write-back register address.
- wb_mode  out  1  one-cycle write strobe; drives register file mode (1 = write).
- wb_addr  out  ADDR_W  write-back address.
- wb_value  out  WIDTH  write-back data.
- carry  out  1  carry/borrow/overflow flag of the last result.
- zero  out  1  high when the last result == 0.
- busy  out  1  high in MUL or WB.

Behaviour:
- Reset (reset = 0, async):
  - state goes to IDLE.
  - in_ready = 1 while reset is deasserted in IDLE; wb_mode = 0, wb_addr = 0, wb_value = 0, carry = 0, zero = 0, busy = 0.
- States: IDLE, MUL, WB.
- Accept: edge where state = IDLE and in_valid = 1. Capture opcode, op1, op2 and dest_addr at that edge. Operands are never re-sampled afterwards.
- Non-MUL ops: accept at edge N moves the state to WB with the result registered. wb_mode = 1 for exactly the cycle after N, then the state returns to IDLE. Throughput is 1 op per 2 cycles.
- MUL: accept at edge N moves the state to MUL.
  - One shift-add step per edge for MUL_CYCLES edges.
  - Product is complete at edge N+16; the state then moves to WB and wb_mode = 1 in cycle N+17.
- in_valid while busy is ignored and not queued.
- Arithmetic rules:
  - ADD: {carry, result} = op1 + op2 (17-bit).
  - SUB: result = op1 - op2 mod 2^16; carry = 1 when op1 < op2 (unsigned borrow).
  - AND/OR/XOR: bitwise; carry = 0.
  - SLL/SRL: shift by op2[3:0]; op2[15:4] ignored; zero fill; carry = 0.
  - MUL: unsigned 16x16; result = product[15:0]; carry = 1 when product[31:16] != 0.
- carry, zero, wb_addr and wb_value update only on entry to WB and hold otherwise. wb_mode = 0 outside WB.
- Reset asserted mid-MUL or in WB: the operation is abandoned, no write strobe is issued, and all outputs go to their reset values.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL implemented as above, using the multiplier sub-module.
- Undefined: no multiplier logic and MUL state unreachable. Opcode 110 completes like a single-cycle op with result = 0, carry = 0, zero = 1, and the write-back still occurs.

Decomposition:
- Shared package alu_pkg: WIDTH/ADDR_W constants, opcode localparams (OP_ADD..OP_SRL), state encoding (S_IDLE, S_MUL, S_WB).
- One sub-module: shift_add_mult_16bit (start/done handshake, iterative, 32-bit product), instantiated only under ALU_MUL_EN.

Test Plan:
- Release reset; ADD op1 = 0x1232, op2 = 0x1263, dest = 2 -> next cycle wb_mode = 1 for one cycle, wb_addr = 2, wb_value = 0x2495, carry = 0, zero = 0.
- ADD 0xFFFF + 0x0001, dest = 5 -> wb_value = 0x0000, carry = 1, zero = 1.
- SUB 0x1263 - 0xA06B -> wb_value = 0x71F8, carry = 1; then SLL 0x0001 by op2 = 0x0013 -> 0x0008, carry = 0.
- MUL 0x0100 * 0x0123, dest = 7 (ALU_MUL_EN defined) -> in_ready low 17 cycles; extra in_valid pulses ignored; wb_mode at cycle N+17; wb_value = 0x2300, carry = 1.
- Reset asserted 5 cycles into MUL -> wb_mode never pulses; outputs 0; in_ready = 1 after release; a subsequent ADD completes normally.
- ALU_MUL_EN undefined: opcode 110 with any operands -> wb_mode in cycle N+1, wb_value = 0, zero = 1, carry = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, opcodes and state encoding for the 16-bit execute stage.
package alu_pkg;

    localparam int WIDTH      = 16;
    localparam int ADDR_W     = 5;
    localparam int MUL_CYCLES = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult_16bit.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// done is asserted during the last step; product then already includes that step.
module shift_add_mult_16bit #(
    parameter int WIDTH  = 16,
    parameter int CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = run && (cnt == CW'(CYCLES - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_16bit.sv
// Execute stage feeding the register-file write port. Define ALU_MUL_EN for the iterative
// multiplier; without it opcode 110 writes back zero after a single cycle.
module alu_exec_16bit #(
    parameter int WIDTH      = alu_pkg::WIDTH,
    parameter int ADDR_W     = alu_pkg::ADDR_W,
    parameter int MUL_CYCLES = alu_pkg::MUL_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic              wb_mode,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_value,
    output logic              carry,
    output logic              zero,
    output logic              busy
);

    import alu_pkg::*;

    localparam int SH_W = $clog2(WIDTH);

    if (MUL_CYCLES != WIDTH) begin : g_cfg_check
        $error("alu_exec_16bit: MUL_CYCLES must equal WIDTH");
    end

    state_t             state;
    logic [ADDR_W-1:0]  dest_q;
    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     alu_res;

    // {carry, result} for every single-cycle opcode; MUL yields zero here.
    function automatic logic [WIDTH:0] alu_calc(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {a < b, a - b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SLL:  r = {1'b0, a << b[SH_W-1:0]};
            OP_SRL:  r = {1'b0, a >> b[SH_W-1:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_res  = alu_calc(opcode, op1, op2);
    assign accept   = (state == S_IDLE) && in_valid;
    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

`ifdef ALU_MUL_EN
    assign is_mul = (opcode == OP_MUL);

    shift_add_mult_16bit #(
        .WIDTH  (WIDTH),
        .CYCLES (MUL_CYCLES)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (op1),
        .b       (op2),
        .done    (mul_done),
        .product (product)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign product  = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            dest_q   <= '0;
            wb_mode  <= 1'b0;
            wb_addr  <= '0;
            wb_value <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
        end else begin
            wb_mode <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dest_q <= dest_addr;
                        if (is_mul) begin
                            state <= S_MUL;
                        end else begin
                            state    <= S_WB;
                            wb_mode  <= 1'b1;
                            wb_addr  <= dest_addr;
                            wb_value <= alu_res[WIDTH-1:0];
                            carry    <= alu_res[WIDTH];
                            zero     <= (alu_res[WIDTH-1:0] == '0);
                        end
                    end
                end
                S_MUL: begin
                    // Final shift-add step lands in the same edge that enters WB.
                    if (mul_done) begin
                        state    <= S_WB;
                        wb_mode  <= 1'b1;
                        wb_addr  <= dest_q;
                        wb_value <= product[WIDTH-1:0];
                        carry    <= |product[2*WIDTH-1:WIDTH];
                        zero     <= (product[WIDTH-1:0] == '0);
                    end
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_16bit.sv
// Bench for alu_exec_16bit: directed literal cases plus random traffic checked every cycle
// against an operation-level reference model.
module tb_alu_exec_16bit;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  opcode = 3'd0;
    logic [15:0] op1 = 16'd0;
    logic [15:0] op2 = 16'd0;
    logic [4:0]  dest_addr = 5'd0;
    logic        wb_mode;
    logic [4:0]  wb_addr;
    logic [15:0] wb_value;
    logic        carry;
    logic        zero;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_16bit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .op1       (op1),
        .op2       (op2),
        .dest_addr (dest_addr),
        .wb_mode   (wb_mode),
        .wb_addr   (wb_addr),
        .wb_value  (wb_value),
        .carry     (carry),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // {carry, result} straight from the arithmetic rules
    function automatic logic [16:0] ref_calc(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        int unsigned ua, ub, s;
        ua = a;
        ub = b;
        case (op)
            3'd0: begin s = ua + ub; return s[16:0]; end
            3'd1: begin s = ua - ub; return {ua < ub, s[15:0]}; end
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: begin s = ua << (ub % 16); return {1'b0, s[15:0]}; end
            3'd6: begin
                if (!MUL_EN) return 17'd0;
                s = ua * ub;
                return {(s >> 16) != 0, s[15:0]};
            end
            default: begin s = ua >> (ub % 16); return {1'b0, s[15:0]}; end
        endcase
    endfunction

    // Model: cycles left until idle; the write-back is visible while one cycle remains.
    int          m_left = 0;
    logic [15:0] m_val = 0, p_val = 0;
    logic [4:0]  m_addr = 0, p_addr = 0;
    logic        m_c = 0, m_z = 0, p_c = 0, p_z = 0;

    always @(posedge clk or negedge reset) begin
        logic [16:0] r;
        if (!reset) begin
            m_left = 0; m_val = 0; m_addr = 0; m_c = 0; m_z = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1) begin
                m_val = p_val; m_addr = p_addr; m_c = p_c; m_z = p_z;
            end
        end else if (in_valid) begin
            r = ref_calc(opcode, op1, op2);
            p_val = r[15:0]; p_c = r[16]; p_z = (r[15:0] == 16'd0); p_addr = dest_addr;
            if (opcode == 3'd6 && MUL_EN) begin
                m_left = 17;
            end else begin
                m_left = 1;
                m_val = p_val; m_addr = p_addr; m_c = p_c; m_z = p_z;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("cyc_wb_mode", wb_mode, m_left == 1);
            chk("cyc_busy", busy, m_left != 0);
            chk("cyc_wb_addr", wb_addr, m_addr);
            chk("cyc_wb_value", wb_value, m_val);
            chk("cyc_carry", carry, m_c);
            chk("cyc_zero", zero, m_z);
            if (reset) chk("cyc_in_ready", in_ready, m_left == 0);
        end
    end

    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [4:0] d, input logic [15:0] ev,
                          input logic ec, input logic ez, input bit poke);
        int cyc;
        int exp_lat;
        exp_lat = (op == 3'd6 && MUL_EN) ? 16 : 0;
        @(negedge clk);
        chk({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1; opcode = op; op1 = a; op2 = b; dest_addr = d;
        @(negedge clk);
        in_valid = 1'b0; op1 = $urandom; op2 = $urandom; dest_addr = $urandom;
        cyc = 0;
        while (wb_mode !== 1'b1 && cyc < 40) begin
            if (poke) begin
                in_valid = $urandom_range(0, 1);
                opcode = $urandom_range(0, 7);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_addr"}, wb_addr, d);
        chk({tag, "_value"}, wb_value, ev);
        chk({tag, "_carry"}, carry, ec);
        chk({tag, "_zero"}, zero, ez);
        @(negedge clk);
        chk({tag, "_strobe_len"}, wb_mode, 0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int pulses;
        reset = 1'b1;
        #1 reset = 1'b0;

        chk("model_add", ref_calc(3'd0, 16'h1232, 16'h1263), 17'h02495);
        chk("model_sub", ref_calc(3'd1, 16'h1263, 16'hA06B), 17'h171F8);
        chk("model_sll", ref_calc(3'd5, 16'h0001, 16'h0013), 17'h00008);
        chk("model_srl", ref_calc(3'd7, 16'h8000, 16'hFFFF), 17'h00001);

        repeat (3) @(negedge clk);
        chk("rst_wb_mode", wb_mode, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_value", wb_value, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        run_op("add_basic", 3'd0, 16'h1232, 16'h1263, 5'd2, 16'h2495, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 5'd5, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("sub_borrow", 3'd1, 16'h1263, 16'hA06B, 5'd3, 16'h71F8, 1'b1, 1'b0, 1'b0);
        run_op("sll_mask", 3'd5, 16'h0001, 16'h0013, 5'd4, 16'h0008, 1'b0, 1'b0, 1'b0);
        run_op("xor_self", 3'd4, 16'hA5A5, 16'hA5A5, 5'd31, 16'h0000, 1'b0, 1'b1, 1'b0);
        if (MUL_EN)
            run_op("mul", 3'd6, 16'h0100, 16'h0123, 5'd7, 16'h2300, 1'b1, 1'b0, 1'b1);
        else
            run_op("mul_off", 3'd6, 16'h0100, 16'h0123, 5'd7, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Abort a multiply five cycles in
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'd6; op1 = 16'h0100; op2 = 16'h0123; dest_addr = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (wb_mode) pulses++;
        end
        chk("abort_wb_value", wb_value, 0);
        chk("abort_busy", busy, 0);
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wb_mode) pulses++;
        end
        chk("abort_pulses", pulses, 0);
        chk("abort_in_ready", in_ready, 1);
        run_op("post_abort_add", 3'd0, 16'h0102, 16'h0304, 5'd9, 16'h0406, 1'b0, 1'b0, 1'b0);

        repeat (500) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            opcode = $urandom_range(0, 7);
            op1 = pick();
            op2 = pick();
            dest_addr = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
